cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/phase_counter.sv | 31 +++
 rtl/cpu_controller.sv | 117 +++++++++++
 tb/tb_cpu_controller.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcode and phase encodings for the CPU controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int OPCODE_W = 3;
    localparam int PHASE_W  = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    typedef enum logic [PHASE_W-1:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    // Opcodes that read an operand from memory and load the accumulator.
    function automatic logic is_aluop(input logic [OPCODE_W-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) ||
               (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/phase_counter.sv
// ============================================================================
// Module      : phase_counter
// Description : Free-running wrapping phase counter with a hold input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_counter
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_hold,
    output logic [PHASE_W-1:0] o_count
);

    logic [PHASE_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (!i_hold) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/cpu_controller.sv
// ============================================================================
// Module      : cpu_controller
// Description : Eight-phase sequencer and control-strobe decoder for a simple
//               accumulator CPU, with a sticky halt cleared only by reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_controller
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                inc_pc,
    output logic                ld_pc,
    output logic                ld_ac,
    output logic                data_e,
    output logic                wr,
    output logic                halt,
    output logic [PHASE_W-1:0]  phase
);

    logic [PHASE_W-1:0] w_phase;
    logic               r_halted;
    logic               w_halt_now;
    logic               w_aluop;
    logic               w_skz;
    logic               w_sto;
    logic               w_jmp;

    assign w_aluop = is_aluop(opcode);
    assign w_skz   = (opcode == OP_SKZ);
    assign w_sto   = (opcode == OP_STO);
    assign w_jmp   = (opcode == OP_JMP);

    // Holding the counter on the same edge that sets the flag freezes phase at 4.
    assign w_halt_now = !r_halted && (w_phase == PH_OP_ADDR) && (opcode == OP_HLT);

    phase_counter u_phase_counter (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (r_halted | w_halt_now),
        .o_count (w_phase)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (w_halt_now) begin
            r_halted <= 1'b1;
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        data_e = 1'b0;
        wr     = 1'b0;
        halt   = 1'b0;
        if (r_halted) begin
            halt = 1'b1;
        end else begin
            case (phase_t'(w_phase))
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                PH_OP_FETCH: begin
                    rd = w_aluop;
                end
                PH_ALU_OP: begin
                    rd     = w_aluop;
                    inc_pc = w_skz & zero;
                    ld_pc  = w_jmp;
                    data_e = w_sto;
                end
                PH_STORE: begin
                    rd     = w_aluop;
                    ld_ac  = w_aluop;
                    inc_pc = w_jmp;
                    ld_pc  = w_jmp;
                    data_e = w_sto;
                    wr     = w_sto;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign phase = w_phase;

endmodule

`default_nettype wire

// File: tb/tb_cpu_controller.sv
// ============================================================================
// Module      : tb_cpu_controller
// Description : Directed self-checking bench for cpu_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_controller;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;
    int incs;

    // Expected strobes packed as {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,data_e,wr,halt}
    logic [8:0] outs;
    logic [8:0] e_add [8];
    logic [8:0] e_sto [8];
    logic [8:0] e_jmp [8];
    logic [8:0] e_skz1[8];
    logic [8:0] e_skz0[8];
    logic [8:0] e_hlt [5];

    assign outs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt};

    cpu_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .data_e (data_e),
        .wr     (wr),
        .halt   (halt),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts sampled at phase 0, ends sampled at phase 0 of the next instruction.
    task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                             input logic [8:0] exp [8]);
        opcode = op;
        zero   = z;
        incs   = 0;
        #1;
        for (int p = 0; p < 8; p++) begin
            check($sformatf("%s_phase%0d", name, p), 32'(phase), 32'(p));
            check($sformatf("%s_outs%0d", name, p), 32'(outs), 32'(exp[p]));
            check($sformatf("%s_wr_rd%0d", name, p), 32'(wr & rd), 32'd0);
            incs += int'(inc_pc);
            step();
        end
    endtask

    initial begin
        e_add  = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h020, 9'h080, 9'h080, 9'h088};
        e_sto  = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h020, 9'h000, 9'h004, 9'h006};
        e_jmp  = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h020, 9'h000, 9'h010, 9'h030};
        e_skz1 = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h020, 9'h000, 9'h020, 9'h000};
        e_skz0 = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h020, 9'h000, 9'h000, 9'h000};
        e_hlt  = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h021};

        rst    = 1'b1;
        opcode = 3'd2;
        zero   = 1'b0;
        #12;
        check("reset_phase", 32'(phase), 32'd0);
        check("reset_outs", 32'(outs), 32'h100);
        rst = 1'b0;
        #1;
        check("post_reset_phase", 32'(phase), 32'd0);
        check("post_reset_outs", 32'(outs), 32'h100);
        step();
        check("first_edge_phase", 32'(phase), 32'd1);
        for (int i = 0; i < 7; i++) step();
        check("wrap_phase", 32'(phase), 32'd0);

        run_instr("add", 3'd2, 1'b0, e_add);
        check("add_inc_count", 32'(incs), 32'd1);
        run_instr("sto", 3'd6, 1'b0, e_sto);
        run_instr("jmp", 3'd7, 1'b1, e_jmp);
        check("jmp_inc_count", 32'(incs), 32'd2);
        run_instr("skz_z1", 3'd1, 1'b1, e_skz1);
        check("skz_z1_inc_count", 32'(incs), 32'd2);
        run_instr("skz_z0", 3'd1, 1'b0, e_skz0);
        check("skz_z0_inc_count", 32'(incs), 32'd1);

        // Asynchronous reset in the middle of phase 5
        opcode = 3'd2;
        for (int i = 0; i < 5; i++) step();
        check("pre_rst_phase", 32'(phase), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_phase", 32'(phase), 32'd0);
        check("midrst_outs", 32'(outs), 32'h100);
        rst = 1'b0;
        step();
        check("midrst_next_phase", 32'(phase), 32'd1);
        for (int i = 0; i < 7; i++) step();
        check("midrst_wrap_phase", 32'(phase), 32'd0);

        // Halt: phase freezes at 4, inputs ignored until reset
        opcode = 3'd0;
        zero   = 1'b0;
        #1;
        for (int p = 0; p < 5; p++) begin
            check($sformatf("hlt_phase%0d", p), 32'(phase), 32'(p));
            check($sformatf("hlt_outs%0d", p), 32'(outs), 32'(e_hlt[p]));
            if (p < 4) step();
        end
        step();
        for (int i = 0; i < 20; i++) begin
            check($sformatf("halted_phase%0d", i), 32'(phase), 32'd4);
            check($sformatf("halted_outs%0d", i), 32'(outs), 32'h001);
            opcode = 3'($urandom_range(0, 7));
            zero   = 1'($urandom_range(0, 1));
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        check("halt_rst_phase", 32'(phase), 32'd0);
        check("halt_rst_outs", 32'(outs), 32'h100);
        rst    = 1'b0;
        opcode = 3'd2;
        step();
        check("halt_rst_next_phase", 32'(phase), 32'd1);
        check("halt_rst_next_outs", 32'(outs), 32'h180);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
